// File: rtl/rr_priority_encoder.sv
// Registered priority encoder / arbiter with a valid/ready handshake on both
// sides. Resolves one winner per accepted request vector, either by fixed
// priority (highest index wins) or round-robin starting at a stored pointer.
// A single output register holds the result; there is no skid buffer.
module rr_priority_encoder #(
    parameter int L = 4,
    parameter int W = $clog2(L)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic [L-1:0] x,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y,
    output logic [L-1:0] grant,
    output logic         none,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [W:0]   L_CNT    = (W+1)'(L);
    localparam logic [W-1:0] LAST_IDX = W'(L - 1);
    localparam logic [L-1:0] ONE_HOT0 = L'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic [L-1:0]   grant_q, grant_d;
    logic           none_q, none_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           accept_s;
    logic [W-1:0]   win_s;

    // Highest set index of req; req is known non-zero where the result is used.
    function automatic logic [W-1:0] fixed_pick(input logic [L-1:0] req);
        logic [W-1:0] win;
        win = '0;
        for (int i = 0; i < L; i++) begin
            if (req[i]) begin
                win = i[W-1:0];
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // First set index searching ptr, ptr+1, ..., wrapping explicitly at L so
    // non-power-of-2 request counts work.
    function automatic logic [W-1:0] rr_pick(input logic [L-1:0] req,
                                             input logic [W-1:0] p);
        logic [W-1:0] win;
        logic         found;
        logic [W:0]   idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < L; k++) begin
            idx = {1'b0, p} + k[W:0];
            if (idx >= L_CNT) begin
                idx = idx - L_CNT;
            end else begin
                idx = idx;
            end
            if (!found && req[idx[W-1:0]]) begin
                win   = idx[W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Handshake: a single output register can take new data when empty or draining.
    always_comb begin
        in_ready  = (state_q == ST_EMPTY) | out_ready;
        accept_s  = in_valid & in_ready;
        win_s     = mode ? rr_pick(x, ptr_q) : fixed_pick(x);
    end

    // Next-state logic of the EMPTY/FULL output register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result and round-robin pointer update on accept; otherwise hold.
    always_comb begin
        y_d     = y_q;
        grant_d = grant_q;
        none_d  = none_q;
        ptr_d   = ptr_q;
        if (accept_s) begin
            if (x == '0) begin
                y_d     = '0;
                grant_d = '0;
                none_d  = 1'b1;
                ptr_d   = ptr_q;
            end else begin
                y_d     = win_s;
                grant_d = ONE_HOT0 << win_s;
                none_d  = 1'b0;
                if (mode) begin
                    ptr_d = (win_s == LAST_IDX) ? '0 : win_s + W'(1);
                end else begin
                    ptr_d = ptr_q;
                end
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State, result and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            grant_q <= '0;
            none_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            grant_q <= grant_d;
            none_q  <= none_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output decode straight from the registers.
    always_comb begin
        out_valid = (state_q == ST_FULL);
        y         = y_q;
        grant     = grant_q;
        none      = none_q;
    end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder (L=4). A cycle-level reference model
// pushes the expected result onto a queue whenever it predicts an accept; the
// head of the queue is compared against the DUT output while it is valid and
// popped when the downstream consumes it.
module tb_rr_priority_encoder;

    localparam int L = 4;
    localparam int W = $clog2(L);

    typedef struct packed {
        logic [W-1:0] y;
        logic [L-1:0] g;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic [L-1:0] x = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] y;
    logic [L-1:0] grant;
    logic         none;
    logic         out_valid;
    logic         out_ready = 1'b0;

    exp_t q[$];
    int   m_ptr   = 0;
    bit   m_valid = 1'b0;
    int   nerr    = 0;
    int   nchk    = 0;

    rr_priority_encoder #(.L(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .grant     (grant),
        .none      (none),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference prediction for one accepted vector; updates the model pointer.
    function automatic exp_t predict(input logic m, input logic [L-1:0] xv);
        exp_t e;
        int   w;
        e = '0;
        w = -1;
        if (xv == '0) begin
            e.n = 1'b1;
        end else begin
            if (!m) begin
                for (int i = L - 1; i >= 0; i--)
                    if (w < 0 && xv[i]) w = i;
            end else begin
                for (int k = 0; k < L; k++)
                    if (w < 0 && xv[(m_ptr + k) % L]) w = (m_ptr + k) % L;
                m_ptr = (w + 1) % L;
            end
            e.y    = W'(w);
            e.g    = '0;
            e.g[w] = 1'b1;
        end
        return e;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cycle(input logic m, input logic [L-1:0] xv, input logic iv,
                         input logic ordy);
        exp_t e;
        bit   exp_rdy;
        mode = m; x = xv; in_valid = iv; out_ready = ordy;
        #1;
        exp_rdy = !m_valid || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            if (q.size() == 0) begin
                chk("queue_nonempty", 32'd0, 32'd1);
            end else begin
                e = q[0];
                chk("y", 32'(y), 32'(e.y));
                chk("grant", 32'(grant), 32'(e.g));
                chk("none", 32'(none), 32'(e.n));
                if (ordy) begin
                    void'(q.pop_front());
                    m_valid = 1'b0;
                end
            end
        end
        if (iv && exp_rdy) begin
            q.push_back(predict(m, xv));
            m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_none", 32'(none), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        do_reset();

        // Fixed priority: highest set index wins
        cycle(1'b0, 4'b0110, 1'b1, 1'b1);
        cycle(1'b0, 4'b0001, 1'b1, 1'b1);
        cycle(1'b0, 4'b1011, 1'b1, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);

        // Round-robin, all requesting: 0,1,2,3,0
        repeat (5) cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1);

        // Move ptr to 2, then 0011 -> 0 (ptr 1), 0011 -> 1 (ptr 2)
        cycle(1'b1, 4'b0010, 1'b1, 1'b1);
        cycle(1'b1, 4'b0011, 1'b1, 1'b1);
        cycle(1'b1, 4'b0011, 1'b1, 1'b1);

        // Fixed mode leaves ptr alone; round-robin resumes from ptr=2
        cycle(1'b0, 4'b0011, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);

        // Zero request: none=1, ptr unchanged (next rr winner is 3)
        cycle(1'b1, 4'b0000, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);

        // Backpressure: held result stable, offered vectors refused
        cycle(1'b1, 4'b0100, 1'b1, 1'b0);
        cycle(1'b1, 4'b1000, 1'b1, 1'b0);
        cycle(1'b0, 4'b0001, 1'b1, 1'b0);
        cycle(1'b0, 4'b0001, 1'b1, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);

        // Reset while FULL under backpressure discards result and clears ptr
        cycle(1'b1, 4'b0010, 1'b1, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1);

        // Random mix of modes, requests and handshakes
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom), L'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0));
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
